nolinear_loader: RTL

NOLINEAR_LOADER -- requirements
Module: nolinear_loader

---
 rtl/nolinear_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nolinear_loader.sv
// nolinear_loader: collects a stream of signed int8 beats into a DATA_NUM-lane
// vector, hands it to the non-linear stage with a one-cycle start pulse and
// holds it until the stage reports completion.
//
// Optional feature: define NOLINEAR_LOADER_TIMEOUT_EN to add a watchdog on the
// WAIT state (TIMEOUT_CYCLES cycles without nl_done) and the timeout_err port.
// Without the macro the loader waits for nl_done indefinitely.
module nolinear_loader #(
    parameter int DATA_NUM       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    input  logic [1:0]            s_mode,
    output logic                  s_ready,
    output logic [DATA_NUM*8-1:0] vec_out,
    output logic [1:0]            mode_out,
    output logic                  en_out,
    input  logic                  nl_done,
    output logic                  busy
`ifdef NOLINEAR_LOADER_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    localparam int CNT_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    // Elaboration guard: both limits must be at least one.
    if (DATA_NUM < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("nolinear_loader: DATA_NUM and TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             lane_last;

`ifdef NOLINEAR_LOADER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] wait_cnt;
    logic            wait_expired;

    // The watchdog fires on the last of TIMEOUT_CYCLES WAIT cycles.
    assign wait_expired = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    // Beats are taken only while collecting, and never while reset is held.
    assign s_ready   = rst && ((state == ST_IDLE) || (state == ST_FILL));
    assign accept    = s_valid && s_ready;
    assign lane_last = (cnt == CNT_W'(DATA_NUM - 1));
    assign busy      = (state != ST_IDLE);

    // Control FSM, lane counter and the held vector/mode registers.
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // the lane bank is a flop array (not a RAM), so it is reset with the rest
    // and vec_out reads zero while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            vec_out  <= '0;
            mode_out <= 2'b00;
            en_out   <= 1'b0;
`ifdef NOLINEAR_LOADER_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            en_out <= 1'b0;
`ifdef NOLINEAR_LOADER_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // A new vector wipes every lane so a short vector
                        // leaves zeros behind, never stale data.
                        vec_out       <= '0;
                        vec_out[7:0]  <= s_data;
                        mode_out      <= s_mode;
                        if (s_last || DATA_NUM == 1) begin
                            state  <= ST_ISSUE;
                            en_out <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            state <= ST_FILL;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        for (int i = 0; i < DATA_NUM; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                vec_out[i*8 +: 8] <= s_data;
                            end
                        end
                        // Remaining lanes were already cleared at vector start.
                        if (s_last || lane_last) begin
                            state  <= ST_ISSUE;
                            en_out <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
`ifdef NOLINEAR_LOADER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (nl_done) begin
                        state <= ST_IDLE;
                    end
`ifdef NOLINEAR_LOADER_TIMEOUT_EN
                    else if (wait_expired) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
